// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width and the controller state encoding.
package seq_div_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_controller.sv
// Sequencing for the restoring divider: state machine, step counter and the
// load/step/done strobes that drive the datapath, plus the ready pulse and busy.
module div_controller
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic divisor_zero_i,
    output logic load_o,
    output logic step_o,
    output logic done_o,
    output logic ready_o,
    output logic busy_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= (state_q == ST_DONE);
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_o  = 1'b0;
        step_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load_o  = 1'b1;
                    count_d = '0;
                    state_d = divisor_zero_i ? ST_DONE : ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                step_o  = 1'b1;
                count_d = count_q + CW'(1);
                if (count_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready_o = ready_q;
    assign busy_o  = (state_q == ST_DIVIDE);

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. Holds the A/Q/M
// datapath and result registers; sequencing lives in div_controller.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero
);

    logic             load, step, done;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   a_shift, trial;
    logic [WIDTH-1:0] q_shift;

    div_controller #(.WIDTH(WIDTH)) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .divisor_zero_i (divisor == '0),
        .load_o         (load),
        .step_o         (step),
        .done_o         (done),
        .ready_o        (ready),
        .busy_o         (busy)
    );

    assign a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign q_shift = q_q << 1;
    assign trial   = a_shift - {1'b0, m_q};

    always_comb begin
        a_d = a_q;
        q_d = q_q;
        m_d = m_q;
        if (load) begin
            a_d = '0;
            q_d = dividend;
            m_d = divisor;
        end else if (step) begin
            // A negative trial (MSB set) restores the shifted partial remainder.
            a_d    = trial[WIDTH] ? a_shift : trial;
            q_d    = q_shift;
            q_d[0] = ~trial[WIDTH];
        end
    end

    // A zero divisor skips DIVIDE, so Q still holds the untouched dividend.
    always_comb begin
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (done) begin
            if (m_q == '0) begin
                quotient_d  = '1;
                remainder_d = q_q;
                dbz_d       = 1'b1;
            end else begin
                quotient_d  = q_q;
                remainder_d = a_q[WIDTH-1:0];
                dbz_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
